// File: rtl/isp_denoise_3x3.sv
// isp_denoise_3x3: 3x3 Gaussian (1-2-1 / 2-4-2 / 1-2-1, /16) spatial denoise
// for an RGB pixel stream. Two line buffers plus a 3x3 window per channel feed
// the filter. Output at input position (x,y) is the kernel centred on
// (x-1,y-1). Pixels in rows 0-1 or columns 0-1 pass through unfiltered.
// Fixed latency of 3 clk on data, valid and vsync.
// Optional feature macro: ISP_DENOISE_BYPASS_EN adds a per-pixel bypass_i input.
module isp_denoise_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync_i,
  input  logic                  valid_i,
`ifdef ISP_DENOISE_BYPASS_EN
  input  logic                  bypass_i,
`endif
  input  logic [DATA_WIDTH-1:0] r_i,
  input  logic [DATA_WIDTH-1:0] g_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  vsync_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] r_o,
  output logic [DATA_WIDTH-1:0] g_o,
  output logic [DATA_WIDTH-1:0] b_o
);

  localparam int PW = 3 * DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 4;
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);

  logic                  vsync_prev;
  logic                  vsync_rise;
  logic [ADDR_WIDTH-1:0] col;
  logic [1:0]            row;
  logic [ADDR_WIDTH-1:0] col_cur;
  logic [1:0]            row_cur;
  logic                  border;
  logic                  pass_now;
  logic [PW-1:0]         pix_in;
  logic [PW-1:0]         lb0_rd;
  logic [PW-1:0]         lb1_rd;

  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];
  logic [PW-1:0] win [3][3];

  logic          s1_valid;
  logic          s1_vsync;
  logic          s1_pass;
  logic [PW-1:0] s1_raw;
  logic          s2_valid;
  logic          s2_vsync;
  logic          s2_pass;
  logic [PW-1:0] s2_raw;
  logic [SW-1:0] s2_sum [3];
  logic [SW-1:0] sum_c [3];
  logic [SW-1:0] rnd [3];
  logic [PW-1:0] filt_pix;
  logic [PW-1:0] out_pix;

  assign vsync_rise = vsync_i & ~vsync_prev;
  assign col_cur    = vsync_rise ? '0 : col;
  assign row_cur    = vsync_rise ? 2'd0 : row;
  assign border     = (row_cur < 2'd2) || (col_cur < ADDR_WIDTH'(2));
  assign pix_in     = {r_i, g_i, b_i};
  assign lb0_rd     = lb0[col_cur];
  assign lb1_rd     = lb1[col_cur];

`ifdef ISP_DENOISE_BYPASS_EN
  assign pass_now = border | bypass_i;
`else
  assign pass_now = border;
`endif

  // Previous vsync sample for frame-start edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_prev <= 1'b0;
    else        vsync_prev <= vsync_i;
  end

  // Column/row position; a frame start clears them before the same-cycle pixel counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= 2'd0;
    end else if (valid_i) begin
      if (col_cur == COL_LAST) begin
        col <= '0;
        row <= (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
      end else begin
        col <= col_cur + ADDR_WIDTH'(1);
        row <= row_cur;
      end
    end else if (vsync_rise) begin
      col <= '0;
      row <= 2'd0;
    end
  end

  // Line buffers: lb0 holds the previous line, lb1 the line before that (no reset)
  always_ff @(posedge clk) begin
    if (valid_i) begin
      lb0[col_cur] <= pix_in;
      lb1[col_cur] <= lb0_rd;
    end
  end

  // 3x3 window shifts left on each valid pixel; row 0 is oldest line, column 2 newest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (valid_i) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= pix_in;
    end
  end

  // Stage 1: capture qualifiers and the raw pixel alongside the window update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vsync <= 1'b0;
      s1_pass  <= 1'b0;
      s1_raw   <= '0;
    end else begin
      s1_valid <= valid_i;
      s1_vsync <= vsync_i;
      s1_pass  <= pass_now;
      s1_raw   <= pix_in;
    end
  end

  // Weighted kernel sum per channel; weights 1/2/4 are shifts by (row==1)+(col==1)
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      sum_c[ch] = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          sum_c[ch] = sum_c[ch] +
                      (SW'(win[r][c][ch*DATA_WIDTH +: DATA_WIDTH]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
    end
  end

  // Stage 2: register kernel sums and carry the raw pixel along
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_vsync <= 1'b0;
      s2_pass  <= 1'b0;
      s2_raw   <= '0;
      for (int ch = 0; ch < 3; ch++) s2_sum[ch] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_vsync <= s1_vsync;
      s2_pass  <= s1_pass;
      s2_raw   <= s1_raw;
      for (int ch = 0; ch < 3; ch++) s2_sum[ch] <= sum_c[ch];
    end
  end

  // Round-to-nearest divide by 16 and select filtered or raw pixel
  always_comb begin
    filt_pix = '0;
    for (int ch = 0; ch < 3; ch++) begin
      rnd[ch] = s2_sum[ch] + SW'(8);
      filt_pix[ch*DATA_WIDTH +: DATA_WIDTH] = rnd[ch][SW-1:4];
    end
    out_pix = s2_pass ? s2_raw : filt_pix;
  end

  // Output register; pixel channels hold their last value while valid_o is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      vsync_o <= 1'b0;
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
    end else begin
      valid_o <= s2_valid;
      vsync_o <= s2_vsync;
      if (s2_valid) begin
        r_o <= out_pix[3*DATA_WIDTH-1:2*DATA_WIDTH];
        g_o <= out_pix[2*DATA_WIDTH-1:DATA_WIDTH];
        b_o <= out_pix[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_isp_denoise_3x3.sv
// tb_isp_denoise_3x3: directed self-checking bench for isp_denoise_3x3 on an
// 8x8 frame (IMG_WIDTH=8). Define ISP_DENOISE_BYPASS_EN to also cover bypass_i.
module tb_isp_denoise_3x3;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync_i;
  logic       valid_i;
`ifdef ISP_DENOISE_BYPASS_EN
  logic       bypass_i;
`endif
  logic [7:0] r_i, g_i, b_i;
  logic       vsync_o, valid_o;
  logic [7:0] r_o, g_o, b_o;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] pix;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] fr [H][W];
  int          out_r [H][W];
  int          out_g [H][W];
  int          out_b [H][W];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        vh [3];
  logic [23:0] last_pix;

  always #5 clk = ~clk;

  isp_denoise_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(W), .ADDR_WIDTH(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (vsync_i),
    .valid_i (valid_i),
`ifdef ISP_DENOISE_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .r_i     (r_i),
    .g_i     (g_i),
    .b_i     (b_i),
    .vsync_o (vsync_o),
    .valid_o (valid_o),
    .r_o     (r_o),
    .g_o     (g_o),
    .b_o     (b_o)
  );

  // Cycle counter used to time-stamp expected outputs
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: Gaussian centred on (x-1,y-1), raw pixel on borders or bypass
  function automatic logic [23:0] expPix(input int x, input int y, input logic byp);
    logic [23:0] res;
    int          s;
    int          w;
    logic [23:0] p;
    res = '0;
    if (byp || x < 2 || y < 2) return fr[y][x];
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++) begin
          w = (dy == 1 ? 2 : 1) * (dx == 1 ? 2 : 1);
          p = fr[y-2+dy][x-2+dx];
          s += w * int'(p[ch*8 +: 8]);
        end
      res[ch*8 +: 8] = 8'((s + 8) >> 4);
    end
    return res;
  endfunction

  task automatic loadFrame(input int kind, input int val);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0: fr[y][x] = {8'(val), 8'(val), 8'(val)};
          1: fr[y][x] = (x == 3 && y == 3) ? {8'd160, 8'd0, 8'd0} : 24'd0;
          default: fr[y][x] = {8'(10*y+x), 8'(10*y+x), 8'(10*y+x)};
        endcase
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        out_r[y][x] = -1;
        out_g[y][x] = -1;
        out_b[y][x] = -1;
      end
  endtask

  // Output monitor: latency, values, vsync delay, hold and reset behaviour
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      vh[0] = 1'b0; vh[1] = 1'b0; vh[2] = 1'b0;
      last_pix = '0;
      checkOutput("reset_outputs", {6'd0, valid_o, vsync_o, r_o, g_o, b_o}, 32'd0);
    end else begin
      checkOutput("vsync_o_delay", {31'd0, vsync_o}, {31'd0, vh[2]});
      vh[2] = vh[1];
      vh[1] = vh[0];
      vh[0] = vsync_i;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        checkOutput("valid_o_latency", {31'd0, valid_o}, 32'd1);
        if (valid_o) begin
          checkOutput($sformatf("pix_x%0d_y%0d", exp_q[0].x, exp_q[0].y),
                      {8'd0, r_o, g_o, b_o}, {8'd0, exp_q[0].pix});
          out_r[exp_q[0].y][exp_q[0].x] = int'(r_o);
          out_g[exp_q[0].y][exp_q[0].x] = int'(g_o);
          out_b[exp_q[0].y][exp_q[0].x] = int'(b_o);
          last_pix = {r_o, g_o, b_o};
        end
        void'(exp_q.pop_front());
      end else begin
        checkOutput("valid_o_idle", {31'd0, valid_o}, 32'd0);
        checkOutput("hold_idle", {8'd0, r_o, g_o, b_o}, {8'd0, last_pix});
      end
    end
  end

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    checkOutput({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Send one frame; optional gap cycles, reset at (rst_x,rst_y), bypass row
  task automatic applyStimulus(input int gap, input int rst_x, input int rst_y, input int byp_row);
    vsync_i = 1'b1;
    tick();
    tick();
    vsync_i = 1'b0;
    tick();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == rst_x && y == rst_y) begin
          valid_i = 1'b0;
          rst_n = 1'b0;
          #1;
          checkOutput("midrst_r_o", {24'd0, r_o}, 32'd0);
          checkOutput("midrst_valid_o", {31'd0, valid_o}, 32'd0);
          tick();
          tick();
          rst_n = 1'b1;
          tick();
          return;
        end
        valid_i = 1'b1;
        {r_i, g_i, b_i} = fr[y][x];
`ifdef ISP_DENOISE_BYPASS_EN
        bypass_i = (y == byp_row);
`endif
        exp_q.push_back('{x, y, expPix(x, y, y == byp_row), cyc + 3});
        tick();
        valid_i = 1'b0;
        {r_i, g_i, b_i} = 24'h5A5A5A;
`ifdef ISP_DENOISE_BYPASS_EN
        bypass_i = 1'b0;
`endif
        repeat (gap) tick();
      end
      repeat (2) tick();
    end
  endtask

  task automatic checkImpulse(input string pre);
    checkOutput({pre, "_r44"}, 32'(out_r[4][4]), 32'd40);
    checkOutput({pre, "_r54"}, 32'(out_r[4][5]), 32'd20);
    checkOutput({pre, "_r45"}, 32'(out_r[5][4]), 32'd20);
    checkOutput({pre, "_r55"}, 32'(out_r[5][5]), 32'd10);
    checkOutput({pre, "_r33"}, 32'(out_r[3][3]), 32'd10);
    checkOutput({pre, "_r43"}, 32'(out_r[3][4]), 32'd20);
    checkOutput({pre, "_r00"}, 32'(out_r[0][0]), 32'd0);
    checkOutput({pre, "_r77"}, 32'(out_r[7][7]), 32'd0);
    checkOutput({pre, "_g44"}, 32'(out_g[4][4]), 32'd0);
    checkOutput({pre, "_b44"}, 32'(out_b[4][4]), 32'd0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    vsync_i = 1'b0;
    valid_i = 1'b0;
    {r_i, g_i, b_i} = 24'h5A5A5A;
`ifdef ISP_DENOISE_BYPASS_EN
    bypass_i = 1'b0;
`endif
    repeat (3) tick();
    checkOutput("reset_valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("reset_r_o", {24'd0, r_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] flat 100 frame");
    loadFrame(0, 100);
    applyStimulus(0, -1, -1, -1);
    waitDrain("flat");
    checkOutput("flat_r77", 32'(out_r[7][7]), 32'd100);
    checkOutput("flat_g34", 32'(out_g[3][4]), 32'd100);

    $display("[TB] impulse frame, contiguous");
    loadFrame(1, 0);
    applyStimulus(0, -1, -1, -1);
    waitDrain("imp");
    checkImpulse("imp");

    $display("[TB] ramp frame, border pass-through");
    loadFrame(2, 0);
    applyStimulus(0, -1, -1, -1);
    waitDrain("ramp");
    checkOutput("ramp_r05", 32'(out_r[0][5]), 32'd5);
    checkOutput("ramp_r17", 32'(out_r[1][7]), 32'd17);
    checkOutput("ramp_r60", 32'(out_r[6][0]), 32'd60);
    checkOutput("ramp_b61", 32'(out_b[6][1]), 32'd61);
    checkOutput("ramp_r55", 32'(out_r[5][5]), 32'd44);

    $display("[TB] impulse frame, gapped valid");
    loadFrame(1, 0);
    applyStimulus(1, -1, -1, -1);
    waitDrain("gap");
    checkImpulse("gap");

    $display("[TB] all-255 frame");
    loadFrame(0, 255);
    applyStimulus(0, -1, -1, -1);
    waitDrain("sat");
    checkOutput("sat_r55", 32'(out_r[5][5]), 32'd255);
    checkOutput("sat_b77", 32'(out_b[7][7]), 32'd255);

    $display("[TB] mid-frame reset then flat 50 frame");
    loadFrame(2, 0);
    applyStimulus(0, 5, 4, -1);
    loadFrame(0, 50);
    applyStimulus(0, -1, -1, -1);
    waitDrain("rst50");
    checkOutput("rst50_r44", 32'(out_r[4][4]), 32'd50);
    checkOutput("rst50_g22", 32'(out_g[2][2]), 32'd50);
    checkOutput("rst50_b77", 32'(out_b[7][7]), 32'd50);
    checkOutput("rst50_r00", 32'(out_r[0][0]), 32'd50);

`ifdef ISP_DENOISE_BYPASS_EN
    $display("[TB] impulse frame, bypass on row 4");
    loadFrame(1, 0);
    applyStimulus(0, -1, -1, 4);
    waitDrain("byp");
    checkOutput("byp_r44", 32'(out_r[4][4]), 32'd0);
    checkOutput("byp_r45", 32'(out_r[4][5]), 32'd0);
    checkOutput("byp_r54", 32'(out_r[5][4]), 32'd20);
    checkOutput("byp_r43", 32'(out_r[3][4]), 32'd20);
    checkOutput("byp_r55", 32'(out_r[5][5]), 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
